// File: rtl/irig_b_dc_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irig_b_dc_encoder                                                        |
// | Buffers ASCII IRIG-B symbols ('0','1','P') and emits the DC pulse code.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module irig_b_dc_encoder #(
  parameter int SLOT_CYCLES = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       irig_out,
  output logic       busy,
  output logic       frame_start,
  output logic       sym_err,
  output logic       underrun
);

  localparam int c_CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(SLOT_CYCLES - 1);
  localparam logic [c_PTR_W:0]   c_FULL_CNT  = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]         c_LAST_IDX  = 4'd9;

  localparam logic [1:0] c_SYM_0 = 2'd0;
  localparam logic [1:0] c_SYM_1 = 2'd1;
  localparam logic [1:0] c_SYM_P = 2'd2;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HIGH = 2'd1;
  localparam logic [1:0] c_ST_LOW  = 2'd2;

  logic [1:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_ready_en;
  logic               r_sym_err;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_slot_cnt;
  logic [3:0]         r_slot_idx;
  logic [3:0]         r_width;
  logic               r_prev_was_p;
  logic               r_fs_pend;
  logic               r_frame_start;
  logic               r_underrun;
  logic               r_irig;

  logic       w_full;
  logic       w_empty;
  logic       w_accept;
  logic       w_sym_ok;
  logic [1:0] w_sym_code;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_head;
  logic [3:0] w_head_width;
  logic       w_slot_end;

  assign w_full     = (r_count == c_FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign sym_ready  = r_ready_en & ~w_full;
  assign w_accept   = sym_valid & sym_ready;
  assign w_push     = w_accept & w_sym_ok;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_slot_end = (r_slot_cnt == c_SLOT_LAST);
  assign w_pop      = ~w_empty & ((r_state == c_ST_IDLE) |
                      ((r_state == c_ST_LOW) & w_slot_end & (r_slot_idx == c_LAST_IDX)));

  always_comb begin
    w_sym_ok   = 1'b1;
    w_sym_code = c_SYM_0;
    case (sym_data)
      8'h30:   w_sym_code = c_SYM_0;
      8'h31:   w_sym_code = c_SYM_1;
      8'h50:   w_sym_code = c_SYM_P;
      default: w_sym_ok   = 1'b0;
    endcase
  end

  // High width in slots for the symbol at the FIFO head
  always_comb begin
    w_head_width = 4'd2;
    case (w_head)
      c_SYM_1: w_head_width = 4'd5;
      c_SYM_P: w_head_width = 4'd8;
      default: w_head_width = 4'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_sym_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
      r_sym_err  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_sym_err  <= w_accept & ~w_sym_ok;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // irig_out and frame_start trail the state by one cycle so they stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_ST_IDLE;
      r_slot_cnt    <= '0;
      r_slot_idx    <= '0;
      r_width       <= '0;
      r_prev_was_p  <= 1'b0;
      r_fs_pend     <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_irig        <= 1'b0;
    end else begin
      r_fs_pend     <= 1'b0;
      r_underrun    <= 1'b0;
      r_irig        <= (r_state == c_ST_HIGH);
      r_frame_start <= r_fs_pend;
      if (w_pop) begin
        r_state      <= c_ST_HIGH;
        r_slot_cnt   <= '0;
        r_slot_idx   <= '0;
        r_width      <= w_head_width;
        r_fs_pend    <= (w_head == c_SYM_P) & r_prev_was_p;
        r_prev_was_p <= (w_head == c_SYM_P);
      end else begin
        case (r_state)
          c_ST_HIGH: begin
            if (w_slot_end) begin
              r_slot_cnt <= '0;
              r_slot_idx <= r_slot_idx + 4'd1;
              if (r_slot_idx == r_width - 4'd1) r_state <= c_ST_LOW;
            end else begin
              r_slot_cnt <= r_slot_cnt + 1'b1;
            end
          end
          c_ST_LOW: begin
            if (w_slot_end) begin
              r_slot_cnt <= '0;
              if (r_slot_idx == c_LAST_IDX) begin
                r_state      <= c_ST_IDLE;
                r_slot_idx   <= '0;
                r_underrun   <= 1'b1;
                r_prev_was_p <= 1'b0;
              end else begin
                r_slot_idx <= r_slot_idx + 4'd1;
              end
            end else begin
              r_slot_cnt <= r_slot_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign irig_out    = r_irig;
  assign busy        = (r_state != c_ST_IDLE);
  assign frame_start = r_frame_start;
  assign sym_err     = r_sym_err;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_irig_b_dc_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irig_b_dc_encoder                                                     |
// | Directed plus randomized bench with a pulse-level reference model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_irig_b_dc_encoder;

  localparam int SLOT    = 10;
  localparam int SYM_CYC = 10 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sym_data = 8'h00;
  logic       sym_valid = 1'b0;
  logic       sym_ready, irig_out, busy, frame_start, sym_err, underrun;

  irig_b_dc_encoder #(.SLOT_CYCLES(SLOT), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_data    (sym_data),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .irig_out    (irig_out),
    .busy        (busy),
    .frame_start (frame_start),
    .sym_err     (sym_err),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: queue of symbols still to appear on irig_out
  logic [7:0] exp_q[$];
  logic [7:0] sym;
  int  exp_err = 0;
  int  err_cnt = 0, und_cnt = 0, fs_cnt = 0;
  int  high_cnt = 0, cur_w = 0, last_rise = 0, last_hs = 0;
  bit  irig_d = 0, have_prev = 0, idle_since = 1, last_p = 0;

  function automatic int width_of(input logic [7:0] b);
    case (b)
      8'h30:   return 2 * SLOT;
      8'h31:   return 5 * SLOT;
      default: return 8 * SLOT;
    endcase
  endfunction

  function automatic bit is_sym(input logic [7:0] b);
    return (b == 8'h30) || (b == 8'h31) || (b == 8'h50);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      irig_d = 0; high_cnt = 0; have_prev = 0; idle_since = 1; last_p = 0;
    end else begin
      if (irig_out && !irig_d) begin
        check_eq("pulse_has_symbol", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sym   = exp_q.pop_front();
          cur_w = width_of(sym);
          if (have_prev && !idle_since) check_eq("symbol_period", cyc - last_rise, SYM_CYC);
          check_eq("frame_start_at_rise", frame_start, (sym == 8'h50) && last_p);
          last_p = (sym == 8'h50);
        end
        last_rise = cyc; have_prev = 1; idle_since = 0; high_cnt = 1;
      end else if (irig_out) begin
        high_cnt++;
      end else if (irig_d) begin
        check_eq("high_width", high_cnt, cur_w);
      end
      if (frame_start) begin
        fs_cnt++;
        if (!(irig_out && !irig_d)) check_eq("frame_start_stray", frame_start, 0);
      end
      if (underrun) begin
        und_cnt++;
        check_eq("underrun_time", cyc - last_rise, SYM_CYC - 1);
        check_eq("busy_at_underrun", busy, 0);
        idle_since = 1; last_p = 0;
      end
      if (sym_err) err_cnt++;
      irig_d = irig_out;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic [7:0] b, input bit hold);
    int n = 0;
    sym_data  = b;
    sym_valid = 1'b1;
    while (!sym_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait_bound", sym_ready, 1);
    last_hs = cyc + 1;
    if (is_sym(b)) exp_q.push_back(b);
    else exp_err++;
    @(negedge clk);
    if (!hold) sym_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || irig_out || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", (n < 3000), 1);
    @(negedge clk);
  endtask

  int u0, f0, e0, h1, h5, n, len;
  int nvalid;
  logic [7:0] b;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_irig", irig_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", sym_ready, 0);
    check_eq("rst_pulses", {frame_start, sym_err, underrun}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", sym_ready, 1);

    // 1: single '0' latency, width and underrun
    u0 = und_cnt;
    send(8'h30, 0);
    n = 0;
    while (!irig_out && n < 10) begin @(negedge clk); n++; end
    check_eq("t1_latency", cyc - last_hs, 2);
    wait_idle();
    check_eq("t1_underruns", und_cnt - u0, 1);

    // 2: back-to-back '1','P','0'
    u0 = und_cnt; f0 = fs_cnt;
    send(8'h31, 1); send(8'h50, 1); send(8'h30, 0);
    wait_idle();
    check_eq("t2_underruns", und_cnt - u0, 1);
    check_eq("t2_no_frame_start", fs_cnt - f0, 0);

    // 3: PP reference marker
    f0 = fs_cnt;
    send(8'h50, 1); send(8'h50, 1); send(8'h30, 1); send(8'h31, 0);
    wait_idle();
    check_eq("t3_frame_start_count", fs_cnt - f0, 1);

    // 4: invalid byte dropped
    e0 = err_cnt;
    send(8'h41, 1); send(8'h31, 0);
    wait_idle();
    check_eq("t4_sym_err", err_cnt - e0, 1);

    // 5: six symbols with sym_valid held
    u0 = und_cnt;
    send(8'h31, 1); h1 = last_hs;
    send(8'h30, 1); send(8'h50, 1); send(8'h31, 1); send(8'h30, 1);
    h5 = last_hs;
    check_eq("t5_fifo_full_ready", sym_ready, 0);
    check_eq("t5_fifth_accept", h5 - h1, 4);
    send(8'h50, 0);
    check_eq("t5_sixth_accept", last_hs - h1, SYM_CYC + 2);
    wait_idle();
    check_eq("t5_underruns", und_cnt - u0, 1);

    // 6: reset in the middle of a 'P' high with more symbols queued
    send(8'h50, 1); send(8'h31, 1); send(8'h30, 0);
    n = 0;
    while (!(irig_out && high_cnt == 30) && n < 500) begin @(negedge clk); n++; end
    check_eq("t6_reached_mid_p", high_cnt, 30);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check_eq("t6_irig_async", irig_out, 0);
    check_eq("t6_busy_async", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t6_fifo_flushed", {busy, irig_out}, 0);
    u0 = und_cnt;
    send(8'h30, 0);
    wait_idle();
    check_eq("t6_underruns", und_cnt - u0, 1);

    // Randomized bursts of symbols mixed with occasional junk bytes
    for (int it = 0; it < 8; it++) begin
      u0 = und_cnt;
      nvalid = 0;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 7))
          0, 1:    b = 8'h30;
          2, 3:    b = 8'h31;
          4, 5, 6: b = 8'h50;
          default: begin
            b = 8'($urandom_range(0, 255));
            if (is_sym(b)) b = 8'h7E;
          end
        endcase
        if (is_sym(b)) nvalid++;
        send(b, k != len - 1);
      end
      wait_idle();
      check_eq("rand_underruns", und_cnt - u0, (nvalid > 0) ? 1 : 0);
    end

    check_eq("sym_err_total", err_cnt, exp_err);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/irig_b_dc_encoder.md
Name: irig_b_dc_encoder

Overview:
- Downstream stage of the UART-to-IRIG-B front end. Consumes the decoded IRIG-B symbol stream: one ASCII byte per symbol, '0' (0x30), '1' (0x31) or 'P' (0x50).
- Converts that stream into a continuous IRIG-B DC level-shift (pulse-width) waveform, one symbol every 10 slots.
- Buffers symbols in a small FIFO so UART byte jitter does not break the 100 Hz symbol cadence.
- Flags reference-marker (PP) frame starts, invalid bytes and underruns.

Parameters:
- SLOT_CYCLES, 50000: clk cycles per 1 ms slot at 50 MHz. The bench overrides this to 10.
- FIFO_DEPTH, 4: symbol FIFO entries. Must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sym_data  in  8  ASCII symbol byte
- sym_valid  in  1  sym_data is valid
- sym_ready  out  1  block can accept a byte this cycle
- irig_out  out  1  IRIG-B DC code output
- busy  out  1  encoder is emitting a symbol (state is not IDLE)
- frame_start  out  1  1-cycle pulse: start of the second P of a PP pair
- sym_err  out  1  1-cycle pulse: invalid byte was dropped
- underrun  out  1  1-cycle pulse: FIFO was empty at a symbol boundary while running

Behaviour:
- Reset values (asynchronous, while rst=1):
  - irig_out, busy, frame_start, sym_err, underrun = 0.
  - FIFO is emptied.
  - sym_ready = 1 from the first clk edge after reset deasserts.
  - Internal prev_was_P = 0.
- Handshake:
  - A byte transfers on a clk edge where sym_valid & sym_ready.
  - sym_ready = !fifo_full (registered-count based).
  - Only '0', '1' and 'P' are written to the FIFO, encoded in 2 bits (0, 1, P).
  - Any other byte is still accepted and consumed but is not stored; sym_err pulses high the cycle after acceptance.
  - Push and pop in the same cycle are both legal; the count is unchanged.
- High widths in slots: '0' = 2, '1' = 5, 'P' = 8. Symbol period = 10 slots = 10*SLOT_CYCLES cycles.
- State machine IDLE / HIGH / LOW:
  - Counters: slot_cnt runs 0..SLOT_CYCLES-1; slot_idx runs 0..9.
  - IDLE: irig_out = 0. When the FIFO is non-empty, pop it, load width, go to HIGH, and clear slot_cnt and slot_idx. irig_out goes to 1 on the cycle after the pop (registered).
  - HIGH: irig_out = 1. At the end of slot (width-1), go to LOW.
  - LOW: irig_out = 0. At the end of slot 9:
    - FIFO non-empty: pop and re-enter HIGH with no gap, so the next high starts exactly 10*SLOT_CYCLES cycles after the previous high.
    - FIFO empty: go to IDLE and pulse underrun for 1 cycle.
- Latency: a byte accepted at edge k into an empty FIFO while IDLE is popped at edge k+1, and irig_out = 1 from edge k+2.
- frame_start:
  - Pulses in the first HIGH cycle of a 'P' when prev_was_P = 1.
  - prev_was_P updates at each pop.
  - PPP produces pulses on the 2nd and 3rd P.
  - Passing through IDLE clears prev_was_P.
- busy = 1 in HIGH and LOW.
- Full FIFO: sym_ready = 0 and sym_valid is ignored (no drop, no error).
- Reset mid-symbol: irig_out drops immediately (asynchronously), the FIFO is lost, and the block restarts in IDLE.
- Counters are sized $clog2(SLOT_CYCLES) and 4 bits for slot_idx, with no overflow paths.

Test Plan (SLOT_CYCLES=10, FIFO_DEPTH=4):
1. Push '0' while idle. Required: irig_out high for 20 cycles starting 2 cycles after the handshake, then low for 80 cycles, then an underrun pulse and busy returns to 0.
2. Push '1','P','0' back-to-back. Required: high widths 50/80/20 cycles, rising edges exactly 100 cycles apart, a single underrun after the third symbol, and no frame_start.
3. Stream 'P','P','0','1' (the frame reference marker). Required: frame_start is 1 for exactly 1 cycle, coincident with the rising edge of the second P.
4. Push 0x41 ('A') then '1'. Required: sym_err pulses once, the FIFO holds only '1', and irig_out shows a 50-cycle high.
5. Hold sym_valid high with 6 symbols while idle. Required:
   - The first symbol is accepted and popped.
   - sym_ready drops once 4 entries are stored.
   - The remaining symbol is accepted only after the next pop.
   - All 6 symbols are emitted in order with 100-cycle spacing, and no byte is lost.
6. Assert rst for 3 cycles mid-'P' high (cycle 30 of the symbol). Required: irig_out = 0 immediately, busy = 0, the FIFO is empty, and after release a new '0' encodes correctly (20-cycle high).
